// File: rtl/bsg_router_crossbar_rr_o_by_i.sv
// i_els_p x o_els_p packet crossbar with per-input FIFOs and per-output round-robin arbiters.
// Optional per-output grant counters are enabled by defining BSG_XBAR_GRANT_CNT_EN.
module bsg_router_crossbar_rr_o_by_i #(
    parameter int i_els_p       = 4,
    parameter int o_els_p       = 4,
    parameter int width_p       = 32,
    parameter int fifo_els_p    = 2,
    parameter int use_credits_p = 0,
    parameter int drop_header_p = 0,
    localparam int lg_o_lp      = (o_els_p > 1) ? $clog2(o_els_p) : 1,
    localparam int o_width_lp   = (drop_header_p != 0) ? (width_p - lg_o_lp) : width_p
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [i_els_p-1:0]               valid_i,
    input  logic [i_els_p*width_p-1:0]       data_i,
    output logic [i_els_p-1:0]               credit_ready_and_o,
    output logic [o_els_p-1:0]               valid_o,
    output logic [o_els_p*o_width_lp-1:0]    data_o,
    input  logic [o_els_p-1:0]               ready_and_i,
    output logic                             dest_err_o
`ifdef BSG_XBAR_GRANT_CNT_EN
    ,
    output logic [o_els_p*32-1:0]            grant_cnt_o
`endif
);

    localparam int lg_i_lp  = (i_els_p > 1) ? $clog2(i_els_p) : 1;
    localparam int lg_f_lp  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);
    localparam logic [lg_o_lp:0] o_els_lp = (lg_o_lp + 1)'(o_els_p);

    logic [width_p-1:0]  r_mem [i_els_p][fifo_els_p];
    logic [lg_f_lp-1:0]  r_rd_ptr [i_els_p];
    logic [lg_f_lp-1:0]  r_wr_ptr [i_els_p];
    logic [cnt_w_lp-1:0] r_cnt [i_els_p];
    logic                r_init;
    logic [i_els_p-1:0]  r_credit;
    logic                r_dest_err;
    logic [lg_i_lp-1:0]  r_rr_ptr [o_els_p];
    logic [o_els_p-1:0]  r_lock;
    logic [lg_i_lp-1:0]  r_lock_idx [o_els_p];

    logic [width_p-1:0]                w_head [i_els_p];
    logic [i_els_p-1:0]                w_empty;
    logic [i_els_p-1:0]                w_full;
    logic [i_els_p-1:0]                w_legal;
    logic [i_els_p-1:0]                w_drop;
    logic [i_els_p-1:0]                w_ready;
    logic [i_els_p-1:0]                w_enq;
    logic [i_els_p-1:0]                w_deq;
    logic [o_els_p-1:0][i_els_p-1:0]   w_req;
    logic [lg_i_lp-1:0]                w_win [o_els_p];
    logic [width_p-1:0]                w_win_data [o_els_p];
    logic [o_els_p-1:0]                w_valid;
    logic [o_els_p-1:0]                w_hs;

    always_comb begin
        for (int i = 0; i < i_els_p; i++) begin
            w_empty[i] = (r_cnt[i] == '0);
            w_full[i]  = (r_cnt[i] == cnt_w_lp'(fifo_els_p));
            w_head[i]  = r_mem[i][r_rd_ptr[i]];
            w_legal[i] = ({1'b0, w_head[i][lg_o_lp-1:0]} < o_els_lp);
            w_drop[i]  = ~w_empty[i] & ~w_legal[i];
        end
        for (int o = 0; o < o_els_p; o++) begin
            for (int i = 0; i < i_els_p; i++) begin
                w_req[o][i] = ~w_empty[i] & w_legal[i] &
                              (w_head[i][lg_o_lp-1:0] == lg_o_lp'(o));
            end
        end
    end

    // A stalled output keeps its winner locked so a newly arrived higher-priority
    // request cannot swap the packet presented downstream.
    always_comb begin : p_arb
        logic w_found;
        int   w_idx;
        w_found = 1'b0;
        w_idx   = 0;
        for (int o = 0; o < o_els_p; o++) begin
            w_found  = 1'b0;
            w_win[o] = r_rr_ptr[o];
            for (int k = 0; k < i_els_p; k++) begin
                w_idx = (int'(r_rr_ptr[o]) + k) % i_els_p;
                if (!w_found && w_req[o][w_idx]) begin
                    w_found  = 1'b1;
                    w_win[o] = lg_i_lp'(w_idx);
                end
            end
            if (r_lock[o]) begin
                w_win[o] = r_lock_idx[o];
            end
            w_valid[o]    = r_init & (|w_req[o]);
            w_hs[o]       = w_valid[o] & ready_and_i[o];
            w_win_data[o] = w_head[w_win[o]];
        end
    end

    always_comb begin
        for (int i = 0; i < i_els_p; i++) begin
            w_deq[i] = w_drop[i];
            for (int o = 0; o < o_els_p; o++) begin
                if (w_hs[o] && (w_win[o] == lg_i_lp'(i))) begin
                    w_deq[i] = 1'b1;
                end
            end
            if (use_credits_p != 0) begin
                w_ready[i] = r_init & r_credit[i];
                w_enq[i]   = valid_i[i] & ~w_full[i];
            end else begin
                w_ready[i] = r_init & ~w_full[i];
                w_enq[i]   = valid_i[i] & w_ready[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < i_els_p; i++) begin
            if (reset_n_i && w_enq[i]) begin
                r_mem[i][r_wr_ptr[i]] <= data_i[i*width_p +: width_p];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < i_els_p; i++) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < i_els_p; i++) begin
                if (w_enq[i]) begin
                    r_wr_ptr[i] <= (r_wr_ptr[i] == lg_f_lp'(fifo_els_p - 1)) ? '0 : r_wr_ptr[i] + 1'b1;
                end
                if (w_deq[i]) begin
                    r_rd_ptr[i] <= (r_rd_ptr[i] == lg_f_lp'(fifo_els_p - 1)) ? '0 : r_rd_ptr[i] + 1'b1;
                end
                if (w_enq[i] && !w_deq[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (!w_enq[i] && w_deq[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_init     <= 1'b0;
            r_credit   <= '0;
            r_dest_err <= 1'b0;
            r_lock     <= '0;
            for (int o = 0; o < o_els_p; o++) begin
                r_rr_ptr[o]   <= '0;
                r_lock_idx[o] <= '0;
            end
        end else begin
            r_init   <= 1'b1;
            r_credit <= w_deq;
            if (|w_drop) begin
                r_dest_err <= 1'b1;
            end
            for (int o = 0; o < o_els_p; o++) begin
                r_lock_idx[o] <= w_win[o];
                if (w_hs[o]) begin
                    r_rr_ptr[o] <= (w_win[o] == lg_i_lp'(i_els_p - 1)) ? '0 : w_win[o] + 1'b1;
                    r_lock[o]   <= 1'b0;
                end else begin
                    r_lock[o]   <= w_valid[o];
                end
            end
        end
    end

    // Overflowing a credit-mode FIFO means the sender ignored its credit count.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && (use_credits_p != 0)) begin
            for (int i = 0; i < i_els_p; i++) begin
                assert (!(valid_i[i] && w_full[i]));
            end
        end
    end

    for (genvar go = 0; go < o_els_p; go++) begin : g_out
        if (drop_header_p != 0) begin : g_strip
            assign data_o[go*o_width_lp +: o_width_lp] = w_win_data[go][width_p-1:lg_o_lp];
        end else begin : g_keep
            assign data_o[go*o_width_lp +: o_width_lp] = w_win_data[go];
        end
    end

    assign valid_o            = w_valid;
    assign credit_ready_and_o = w_ready;
    assign dest_err_o         = r_dest_err;

`ifdef BSG_XBAR_GRANT_CNT_EN
    logic [31:0] r_grant_cnt [o_els_p];

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int o = 0; o < o_els_p; o++) begin
                r_grant_cnt[o] <= '0;
            end
        end else begin
            for (int o = 0; o < o_els_p; o++) begin
                if (w_hs[o]) begin
                    r_grant_cnt[o] <= r_grant_cnt[o] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < o_els_p; o++) begin
            grant_cnt_o[o*32 +: 32] = r_grant_cnt[o];
        end
    end
`endif

endmodule

// File: tb/tb_bsg_router_crossbar_rr_o_by_i.sv
// Directed bench for bsg_router_crossbar_rr_o_by_i: 4x4 ready mode, 4x4 credit mode,
// 3x3 with header stripping; grant counters checked when BSG_XBAR_GRANT_CNT_EN is defined.
module tb_bsg_router_crossbar_rr_o_by_i;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // 4x4 ready mode
    logic [3:0]   rd_valid_i, rd_cr, rd_valid_o, rd_ready;
    logic [31:0]  rd_data_i, rd_data_o;
    logic         rd_err;
    // 4x4 credit mode
    logic [3:0]   cr_valid_i, cr_cr, cr_valid_o, cr_ready;
    logic [31:0]  cr_data_i, cr_data_o;
    logic         cr_err;
    // 3x3 ready mode, header stripped
    logic [2:0]   tx_valid_i, tx_cr, tx_valid_o, tx_ready;
    logic [23:0]  tx_data_i;
    logic [17:0]  tx_data_o;
    logic         tx_err;
`ifdef BSG_XBAR_GRANT_CNT_EN
    logic [127:0] rd_gcnt, cr_gcnt;
    logic [95:0]  tx_gcnt;
`endif

    bsg_router_crossbar_rr_o_by_i #(.i_els_p(4), .o_els_p(4), .width_p(8), .fifo_els_p(2),
                                    .use_credits_p(0), .drop_header_p(0)) u_rdy (
        .clk_i(clk), .reset_n_i(reset_n), .valid_i(rd_valid_i), .data_i(rd_data_i),
        .credit_ready_and_o(rd_cr), .valid_o(rd_valid_o), .data_o(rd_data_o),
        .ready_and_i(rd_ready), .dest_err_o(rd_err)
`ifdef BSG_XBAR_GRANT_CNT_EN
        , .grant_cnt_o(rd_gcnt)
`endif
    );

    bsg_router_crossbar_rr_o_by_i #(.i_els_p(4), .o_els_p(4), .width_p(8), .fifo_els_p(2),
                                    .use_credits_p(1), .drop_header_p(0)) u_crd (
        .clk_i(clk), .reset_n_i(reset_n), .valid_i(cr_valid_i), .data_i(cr_data_i),
        .credit_ready_and_o(cr_cr), .valid_o(cr_valid_o), .data_o(cr_data_o),
        .ready_and_i(cr_ready), .dest_err_o(cr_err)
`ifdef BSG_XBAR_GRANT_CNT_EN
        , .grant_cnt_o(cr_gcnt)
`endif
    );

    bsg_router_crossbar_rr_o_by_i #(.i_els_p(3), .o_els_p(3), .width_p(8), .fifo_els_p(2),
                                    .use_credits_p(0), .drop_header_p(1)) u_3x3 (
        .clk_i(clk), .reset_n_i(reset_n), .valid_i(tx_valid_i), .data_i(tx_data_i),
        .credit_ready_and_o(tx_cr), .valid_o(tx_valid_o), .data_o(tx_data_o),
        .ready_and_i(tx_ready), .dest_err_o(tx_err)
`ifdef BSG_XBAR_GRANT_CNT_EN
        , .grant_cnt_o(tx_gcnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic [7:0] exp_rr [4];
    int         n_pulse;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        rd_valid_i = '0; rd_data_i = '0; rd_ready = '0;
        cr_valid_i = '0; cr_data_i = '0; cr_ready = '0;
        tx_valid_i = '0; tx_data_i = '0; tx_ready = '0;

        // reset and idle
        repeat (3) cyc();
        mid();
        check("rst_valid", rd_valid_o, 4'h0);
        check("rst_ready", rd_cr, 4'h0);
        cyc();
        reset_n = 1'b1;
        mid();
        check("post_rst_ready", rd_cr, 4'h0);
        check("post_rst_valid", rd_valid_o, 4'h0);
        cyc();
        mid();
        check("idle_ready", rd_cr, 4'hF);
        check("idle_valid", rd_valid_o, 4'h0);
        check("idle_err", rd_err, 1'b0);
        check("idle_credit", cr_cr, 4'h0);
        check("idle_ready3", tx_cr, 3'h7);

        // all four inputs to output 2: grants rotate 0,1,2,3,0
        exp_rr = '{8'h02, 8'h42, 8'h82, 8'hC2};
        cyc();
        rd_valid_i = 4'hF;
        rd_data_i  = {8'hC2, 8'h82, 8'h42, 8'h02};
        rd_ready   = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            cyc();
            mid();
            check($sformatf("rr_valid%0d", k), rd_valid_o, 4'b0100);
            check($sformatf("rr_data%0d", k), rd_data_o[23:16], exp_rr[k % 4]);
        end
        rd_valid_i = '0;
        rd_ready   = 4'hF;
        repeat (12) cyc();
        mid();
        check("rr_drained", rd_valid_o, 4'h0);

        // output 1 stalled for 5 cycles behind input 3
        cyc();
        rd_ready   = 4'b1101;
        rd_valid_i = 4'b1000;
        rd_data_i  = {8'h51, 24'h0};
        cyc();
        rd_data_i  = {8'h61, 24'h0};
        mid();
        check("stall_valid1", rd_valid_o, 4'b0010);
        check("stall_data1", rd_data_o[15:8], 8'h51);
        check("stall_rdy1", rd_cr[3], 1'b1);
        cyc();
        rd_data_i  = {8'h71, 24'h0};
        mid();
        check("stall_rdy2", rd_cr[3], 1'b0);
        check("stall_data2", rd_data_o[15:8], 8'h51);
        for (int k = 3; k < 5; k++) begin
            cyc();
            mid();
            check($sformatf("stall_valid%0d", k), rd_valid_o, 4'b0010);
            check($sformatf("stall_data%0d", k), rd_data_o[15:8], 8'h51);
            check($sformatf("stall_rdy%0d", k), rd_cr[3], 1'b0);
        end
        cyc();
        rd_ready = 4'hF;
        mid();
        check("stall_release_data", rd_data_o[15:8], 8'h51);
        check("stall_release_valid", rd_valid_o, 4'b0010);
        cyc();
        mid();
        check("stall_p2_data", rd_data_o[15:8], 8'h61);
        check("stall_p2_rdy", rd_cr[3], 1'b1);
        cyc();
        rd_valid_i = '0;
        mid();
        check("stall_p3_data", rd_data_o[15:8], 8'h71);
        check("stall_p3_valid", rd_valid_o, 4'b0010);
        cyc();
        mid();
        check("stall_empty", rd_valid_o, 4'h0);

        // credit mode: two packets, one idle cycle apart
        n_pulse = 0;
        cyc();
        cr_ready   = 4'hF;
        cr_valid_i = 4'b0001;
        cr_data_i  = 32'h0000_0090;
        cyc();
        cr_valid_i = '0;
        mid();
        check("crd_valid1", cr_valid_o, 4'b0001);
        check("crd_data1", cr_data_o[7:0], 8'h90);
        check("crd_c0", cr_cr, 4'h0);
        cyc();
        cr_valid_i = 4'b0001;
        cr_data_i  = 32'h0000_00A0;
        mid();
        check("crd_c1", cr_cr, 4'b0001);
        check("crd_gone1", cr_valid_o, 4'h0);
        n_pulse += int'(cr_cr[0]);
        cyc();
        cr_valid_i = '0;
        mid();
        check("crd_c2", cr_cr, 4'h0);
        check("crd_data2", cr_data_o[7:0], 8'hA0);
        cyc();
        mid();
        check("crd_c3", cr_cr, 4'b0001);
        n_pulse += int'(cr_cr[0]);
        cyc();
        mid();
        check("crd_c4", cr_cr, 4'h0);
        n_pulse += int'(cr_cr[0]);
        check("crd_pulses", n_pulse, 2);

        // 3x3 illegal destination then a legal packet on the same input
        cyc();
        tx_ready   = 3'h7;
        tx_valid_i = 3'b010;
        tx_data_i  = {8'h00, 8'hAB, 8'h00};
        cyc();
        tx_valid_i = '0;
        mid();
        check("drop_novalid0", tx_valid_o, 3'h0);
        check("drop_err0", tx_err, 1'b0);
        cyc();
        tx_valid_i = 3'b010;
        tx_data_i  = {8'h00, 8'h56, 8'h00};
        mid();
        check("drop_novalid1", tx_valid_o, 3'h0);
        check("drop_err1", tx_err, 1'b1);
        check("drop_slot", tx_cr[1], 1'b1);
        cyc();
        tx_valid_i = '0;
        mid();
        check("legal_valid", tx_valid_o, 3'b100);
        check("legal_data", tx_data_o[17:12], 6'h15);
        cyc();
        mid();
        check("legal_done", tx_valid_o, 3'h0);
        check("err_sticky", tx_err, 1'b1);

        // reset while FIFOs hold packets
        cyc();
        rd_ready   = '0;
        rd_valid_i = 4'hF;
        rd_data_i  = {8'hC1, 8'h81, 8'h41, 8'h01};
        cr_ready   = '0;
        cr_valid_i = 4'b0001;
        cr_data_i  = 32'h0000_0011;
        cyc();
        cr_valid_i = '0;
        repeat (2) cyc();
        mid();
        check("pre_rst_valid", rd_valid_o, 4'b0010);
        cyc();
        reset_n    = 1'b0;
        rd_valid_i = '0;
        repeat (2) cyc();
        reset_n = 1'b1;
        mid();
        check("mid_rst_valid", rd_valid_o, 4'h0);
        check("mid_rst_credit", cr_cr, 4'h0);
        cyc();
        mid();
        check("mid_rst_empty", rd_valid_o, 4'h0);
        check("mid_rst_ready", rd_cr, 4'hF);
        check("mid_rst_nocredit", cr_cr, 4'h0);
        check("mid_rst_cvalid", cr_valid_o, 4'h0);
        check("mid_rst_err", tx_err, 1'b0);

`ifdef BSG_XBAR_GRANT_CNT_EN
        // ten packets to output 0, then reset mid-stream
        cyc();
        rd_ready   = 4'hF;
        rd_valid_i = 4'b0001;
        rd_data_i  = 32'h0000_0000;
        repeat (10) cyc();
        rd_valid_i = '0;
        repeat (4) cyc();
        mid();
        check("gcnt0", rd_gcnt[31:0], 32'd10);
        check("gcnt_rest", rd_gcnt[127:32], 96'd0);
        cyc();
        rd_valid_i = 4'b0001;
        repeat (3) cyc();
        reset_n = 1'b0;
        rd_valid_i = '0;
        repeat (2) cyc();
        reset_n = 1'b1;
        cyc();
        mid();
        check("gcnt_rst", rd_gcnt, 128'd0);
        check("gcnt_rst_valid", rd_valid_o, 4'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
